// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule generator: loads one 16-word block, then streams W[0..NUM_WORDS-1]
// using a 16-entry sliding window instead of a full 64-word schedule memory.
module sha256_msg_schedule #(
    parameter int unsigned NUM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_index,
    output logic        out_last,
    output logic        busy
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

    typedef enum logic {
        LOAD,
        EMIT
    } stateT;

    stateT       state;
    stateT       stateNext;
    logic [3:0]  loadCnt;
    logic [31:0] win [16];
    logic [31:0] newWord;
    logic [5:0]  nextIdx;
    logic        inXfer;
    logic        outXfer;

    function automatic logic [31:0] smallSigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] smallSigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign in_ready = (state == LOAD);
    assign busy     = (state == EMIT);
    assign inXfer   = in_valid && in_ready;
    assign outXfer  = out_valid && out_ready;
    assign nextIdx  = out_index + 6'd1;

    // Window holds W[n-16..n-1] whenever W[n] (n >= 16) is about to be presented
    assign newWord = smallSigma1(win[14]) + win[9] + smallSigma0(win[1]) + win[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            LOAD: if (inXfer && loadCnt == 4'd15) stateNext = EMIT;
            EMIT: if (outXfer && out_last) stateNext = LOAD;
            default: stateNext = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && inXfer) begin
            for (int unsigned i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= in_word;
        end else if (state == EMIT && outXfer && !out_last && nextIdx >= 6'd16) begin
            for (int unsigned i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= newWord;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            loadCnt   <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (inXfer) begin
                        loadCnt <= loadCnt + 4'd1;
                        if (loadCnt == 4'd15) begin
                            // W0 sits in slot 1 until this same edge shifts it to slot 0
                            out_valid <= 1'b1;
                            out_index <= '0;
                            out_word  <= win[1];
                            out_last  <= (LAST_IDX == 6'd0);
                        end
                    end
                end
                EMIT: begin
                    if (outXfer) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            loadCnt   <= '0;
                        end else begin
                            out_index <= nextIdx;
                            out_last  <= (nextIdx == LAST_IDX);
                            out_word  <= (nextIdx < 6'd16) ? win[nextIdx[3:0]] : newWord;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboard bench for sha256_msg_schedule: an independent schedule model fills an expected
// queue as blocks are driven; a negedge monitor pops and compares every output transfer.
module tb_sha256_msg_schedule;

    localparam int unsigned NW = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [31:0] in_word, out_word;
    logic [5:0]  out_index;

    logic        in_valid16, in_ready16, out_valid16, out_last16, busy16;
    logic [31:0] in_word16, out_word16;
    logic [5:0]  out_index16;

    always #5 clk = ~clk;

    sha256_msg_schedule #(.NUM_WORDS(NW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_index(out_index), .out_last(out_last), .busy(busy)
    );

    sha256_msg_schedule #(.NUM_WORDS(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .in_word(in_word16),
        .out_valid(out_valid16), .out_ready(1'b1), .out_word(out_word16),
        .out_index(out_index16), .out_last(out_last16), .busy(busy16)
    );

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] word;
        logic        last;
    } expT;

    expT         sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] blk [16];
    logic [31:0] mw [64];
    logic        randReady = 1'b0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic genModel();
        for (int t = 0; t < 16; t++) mw[t] = blk[t];
        for (int t = 16; t < 64; t++)
            mw[t] = (rotr(mw[t-2], 17) ^ rotr(mw[t-2], 19) ^ (mw[t-2] >> 10)) + mw[t-7]
                  + (rotr(mw[t-15], 7) ^ rotr(mw[t-15], 18) ^ (mw[t-15] >> 3)) + mw[t-16];
    endtask

    task automatic pushExp();
        for (int t = 0; t < NW; t++) begin
            expT e;
            e.idx  = 6'(t);
            e.word = mw[t];
            e.last = (t == NW - 1);
            sbq.push_back(e);
        end
    endtask

    // Called and returns at posedge+1
    task automatic driveWords(input int n, input int gapPct);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            while ($urandom_range(0, 99) < gapPct) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_word  = blk[i];
            @(negedge clk);
            while (!in_ready && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 300) checkVal("in_ready_timeout", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int guard = 0;
        while (sbq.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        checkVal("drain", 32'(sbq.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Loads with out_ready high, counts consecutive valid cycles, checks in_ready right after
    task automatic runTight();
        int cnt = 0;
        int guard = 0;
        driveWords(16, 0);
        @(negedge clk);
        checkVal("first_valid", 32'(out_valid), 32'd1);
        checkVal("busy_emit", 32'(busy), 32'd1);
        checkVal("in_ready_emit0", 32'(in_ready), 32'd0);
        while (out_valid && guard < 300) begin
            cnt++;
            guard++;
            @(negedge clk);
        end
        checkVal("burst_len", 32'(cnt), 32'(NW));
        checkVal("in_ready_after", 32'(in_ready), 32'd1);
        checkVal("sb_left", 32'(sbq.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        logic        stallPrev = 1'b0;
        logic [31:0] pWord;
        logic [5:0]  pIdx;
        logic        pLast;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (stallPrev) begin
                    checkVal("stall_valid", 32'(out_valid), 32'd1);
                    checkVal("stall_word", out_word, pWord);
                    checkVal("stall_idx", 32'(out_index), 32'(pIdx));
                    checkVal("stall_last", 32'(out_last), 32'(pLast));
                end
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        checkVal("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        expT e;
                        e = sbq.pop_front();
                        checkVal("out_index", 32'(out_index), 32'(e.idx));
                        checkVal("out_word", out_word, e.word);
                        checkVal("out_last", 32'(out_last), 32'(e.last));
                    end
                end
            end
            stallPrev = !rst && out_valid && !out_ready;
            pWord = out_word;
            pIdx  = out_index;
            pLast = out_last;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        rst = 1'b1;
        in_valid = 1'b0;
        in_word = '0;
        in_valid16 = 1'b0;
        in_word16 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkVal("rst_out_valid", 32'(out_valid), 32'd0);
        checkVal("rst_out_word", out_word, 32'd0);
        checkVal("rst_out_index", 32'(out_index), 32'd0);
        checkVal("rst_out_last", 32'(out_last), 32'd0);
        checkVal("rst_busy", 32'(busy), 32'd0);
        checkVal("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // "abc" block with known-answer words, then an all-ones block back to back
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0] = 32'h61626380;
        blk[15] = 32'h00000018;
        genModel();
        mw[16] = 32'h61626380;
        mw[17] = 32'h000F0000;
        mw[18] = 32'h7DA86405;
        mw[19] = 32'h600003C6;
        pushExp();
        runTight();
        for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
        genModel();
        pushExp();
        runTight();

        // abc again under input gaps and random backpressure
        randReady = 1'b1;
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0] = 32'h61626380;
        blk[15] = 32'h00000018;
        genModel();
        pushExp();
        driveWords(16, 40);
        waitDrain();

        // all-ones block, with in_valid held during EMIT
        for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
        genModel();
        pushExp();
        driveWords(16, 0);
        in_valid = 1'b1;
        in_word = 32'hDEADBEEF;
        repeat (12) begin
            @(negedge clk);
            checkVal("in_ready_during_emit", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        waitDrain();

        // reset after 9 loaded words, then a fresh random block
        for (int i = 0; i < 16; i++) blk[i] = $urandom();
        driveWords(9, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) blk[i] = $urandom();
        genModel();
        pushExp();
        driveWords(16, 20);
        waitDrain();

        // reset while out_index == 30
        randReady = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) blk[i] = $urandom();
        genModel();
        pushExp();
        driveWords(16, 0);
        guard = 0;
        @(negedge clk);
        while (!(out_valid && out_index == 6'd30) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkVal("reach_idx30", 32'(out_index), 32'd30);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sbq.delete();
        @(negedge clk);
        checkVal("midemit_rst_valid", 32'(out_valid), 32'd0);
        checkVal("midemit_rst_in_ready", 32'(in_ready), 32'd1);
        checkVal("midemit_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        randReady = 1'b1;
        for (int i = 0; i < 16; i++) blk[i] = $urandom();
        genModel();
        pushExp();
        driveWords(16, 30);
        waitDrain();

        // NUM_WORDS=16 instance: pure passthrough
        for (int i = 0; i < 16; i++) blk[i] = $urandom();
        for (int i = 0; i < 16; i++) begin
            in_valid16 = 1'b1;
            in_word16 = blk[i];
            @(negedge clk);
            checkVal("p16_in_ready", 32'(in_ready16), 32'd1);
            @(posedge clk); #1;
        end
        in_valid16 = 1'b0;
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            checkVal("p16_valid", 32'(out_valid16), 32'd1);
            checkVal("p16_index", 32'(out_index16), 32'(t));
            checkVal("p16_word", out_word16, blk[t]);
            checkVal("p16_last", 32'(out_last16), 32'(t == 15));
            checkVal("p16_busy", 32'(busy16), 32'd1);
        end
        @(negedge clk);
        checkVal("p16_done_valid", 32'(out_valid16), 32'd0);
        checkVal("p16_done_in_ready", 32'(in_ready16), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
